ahfp_addsub_pipe: RTL and testbench

AHFP_ADDSUB_PIPE -- requirements
Module: ahfp_addsub_pipe

---
 rtl/ahfp_pkg.sv | 52 +++++
 rtl/ahfp_norm.sv | 28 ++
 rtl/ahfp_addsub_pipe.sv | 196 +++++++++++++++++++
 tb/tb_ahfp_addsub_pipe.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahfp_pkg.sv
// Shared definitions for the ahfp floating-point blocks: default field widths,
// bias derivation, operand classification and canonical special encodings.
package ahfp_pkg;

   localparam int AHFP_EXP_W = 8;
   localparam int AHFP_MAN_W = 23;
   localparam logic [63:0] AHFP_ZERO_BITS = 64'd0;

   typedef enum logic [1:0] {
      CLS_ZERO = 2'd0,
      CLS_NORM = 2'd1,
      CLS_INF  = 2'd2,
      CLS_NAN  = 2'd3
   } ahfp_class_e;

   function automatic int ahfp_bias(input int exp_w);
      return (1 << (exp_w - 1)) - 1;
   endfunction

   // Positive infinity, right-aligned in a 64-bit container.
   function automatic logic [63:0] ahfp_inf_bits(input int exp_w, input int man_w);
      logic [63:0] v;
      v = 64'd0;
      for (int i = 0; i < exp_w; i++) begin
         v[man_w + i] = 1'b1;
      end
      return v;
   endfunction

   function automatic logic [63:0] ahfp_qnan_bits(input int exp_w, input int man_w);
      logic [63:0] v;
      v = ahfp_inf_bits(exp_w, man_w);
      v[man_w - 1] = 1'b1;
      return v;
   endfunction

   function automatic ahfp_class_e ahfp_classify(input logic exp_zero, input logic exp_ones,
                                                 input logic man_nz);
      ahfp_class_e c;
      if (exp_zero) begin
         c = CLS_ZERO;
      end else if (!exp_ones) begin
         c = CLS_NORM;
      end else if (man_nz) begin
         c = CLS_NAN;
      end else begin
         c = CLS_INF;
      end
      return c;
   endfunction

endpackage

// File: rtl/ahfp_norm.sv
// Combinational leading-zero count and left-justifying shift.
module ahfp_norm #(
   parameter int WIDTH = 27,
   parameter int LZW   = $clog2(WIDTH + 1)
) (
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] data_o,
   output logic [LZW-1:0]   lzc_o
);

   logic found_s;

   // Scan from the MSB; an all-zero input reports WIDTH.
   always_comb begin
      lzc_o   = LZW'(WIDTH);
      found_s = 1'b0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (!found_s && data_i[i]) begin
            lzc_o   = LZW'(WIDTH - 1 - i);
            found_s = 1'b1;
         end else begin
            found_s = found_s;
         end
      end
      data_o = data_i << lzc_o;
   end

endmodule

// File: rtl/ahfp_addsub_pipe.sv
// Three-stage floating-point adder/subtractor (align, add, normalise/round)
// with valid/ready flow control; denormals flush to zero.
module ahfp_addsub_pipe
   import ahfp_pkg::*;
#(
   parameter int EXP_W = AHFP_EXP_W,
   parameter int MAN_W = AHFP_MAN_W
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic                   op_sub,
   input  logic [EXP_W+MAN_W:0]   dataa,
   input  logic [EXP_W+MAN_W:0]   datab,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [EXP_W+MAN_W:0]   result
);

   localparam int W       = 1 + EXP_W + MAN_W;
   localparam int MW      = MAN_W + 4;
   localparam int SW      = MAN_W + 5;
   localparam int XW      = EXP_W + 2;
   localparam int LZW     = $clog2(MW + 1);
   localparam int EXP_MAX = 2 * ahfp_bias(EXP_W) + 1;
   localparam logic [W-1:0] QNAN    = W'(ahfp_qnan_bits(EXP_W, MAN_W));
   localparam logic [W-1:0] INF_POS = W'(ahfp_inf_bits(EXP_W, MAN_W));
   localparam logic [W-1:0] ZERO    = W'(AHFP_ZERO_BITS);

   logic en1_s, en2_s, en3_s;
   logic v1_q, v2_q, out_valid_q;
   logic [W-1:0] result_q, result_d;

   ahfp_class_e cls_a_s, cls_b_s;
   logic sb_s, a_big_s;
   logic [W-2:0] mag_a_s, mag_b_s;
   logic [EXP_W-1:0] e_sml_s, diff_s;
   logic [MW-1:0] x_a_s, x_b_s, x_sml_s, mask_s;
   logic spec_d, sign_d, sub_d;
   logic [W-1:0] specres_d;
   logic [EXP_W-1:0] exp_d;
   logic [MW-1:0] big_d, sml_d;

   logic spec1_q, sign1_q, sub1_q;
   logic [W-1:0] specres1_q;
   logic [EXP_W-1:0] exp1_q;
   logic [MW-1:0] big1_q, sml1_q;

   logic [SW-1:0] sum_d;
   logic spec2_q, sign2_q;
   logic [W-1:0] specres2_q;
   logic [EXP_W-1:0] exp2_q;
   logic [SW-1:0] sum2_q;

   logic [MW-1:0] norm_s, m_s;
   logic [LZW-1:0] lzc_s;
   logic [XW-1:0] e_s, ef_s;
   logic rnd_s;
   logic [MAN_W+1:0] mr_s;
   logic [MAN_W-1:0] man_s;

   // A stage may load whenever its successor loads or it currently holds a bubble.
   assign en3_s     = !out_valid_q || out_ready;
   assign en2_s     = en3_s || !v2_q;
   assign en1_s     = en2_s || !v1_q;
   assign in_ready  = en3_s;
   assign out_valid = out_valid_q;
   assign result    = result_q;

   // S1: classify, order by magnitude, align the smaller mantissa with G/R/S.
   always_comb begin
      sb_s    = datab[W-1] ^ op_sub;
      cls_a_s = ahfp_classify(dataa[W-2:MAN_W] == '0, &dataa[W-2:MAN_W], |dataa[MAN_W-1:0]);
      cls_b_s = ahfp_classify(datab[W-2:MAN_W] == '0, &datab[W-2:MAN_W], |datab[MAN_W-1:0]);
      mag_a_s = (cls_a_s == CLS_ZERO) ? '0 : dataa[W-2:0];
      mag_b_s = (cls_b_s == CLS_ZERO) ? '0 : datab[W-2:0];
      x_a_s   = (cls_a_s == CLS_ZERO) ? '0 : {1'b1, dataa[MAN_W-1:0], 3'b000};
      x_b_s   = (cls_b_s == CLS_ZERO) ? '0 : {1'b1, datab[MAN_W-1:0], 3'b000};
      a_big_s = (mag_a_s >= mag_b_s);
      if (a_big_s) begin
         exp_d   = dataa[W-2:MAN_W];
         e_sml_s = datab[W-2:MAN_W];
         big_d   = x_a_s;
         x_sml_s = x_b_s;
         sign_d  = dataa[W-1];
      end else begin
         exp_d   = datab[W-2:MAN_W];
         e_sml_s = dataa[W-2:MAN_W];
         big_d   = x_b_s;
         x_sml_s = x_a_s;
         sign_d  = sb_s;
      end
      diff_s = exp_d - e_sml_s;
      mask_s = ~({MW{1'b1}} << diff_s);
      if (int'(diff_s) >= MAN_W + 3) begin
         sml_d = {{(MW-1){1'b0}}, |x_sml_s};
      end else begin
         sml_d = (x_sml_s >> diff_s) | {{(MW-1){1'b0}}, |(x_sml_s & mask_s)};
      end
      sub_d     = dataa[W-1] ^ sb_s;
      spec_d    = 1'b1;
      specres_d = QNAN;
      if (cls_a_s == CLS_NAN || cls_b_s == CLS_NAN) begin
         specres_d = QNAN;
      end else if (cls_a_s == CLS_INF && cls_b_s == CLS_INF) begin
         specres_d = (dataa[W-1] == sb_s) ? {dataa[W-1], INF_POS[W-2:0]} : QNAN;
      end else if (cls_a_s == CLS_INF) begin
         specres_d = {dataa[W-1], INF_POS[W-2:0]};
      end else if (cls_b_s == CLS_INF) begin
         specres_d = {sb_s, INF_POS[W-2:0]};
      end else begin
         spec_d    = 1'b0;
         specres_d = ZERO;
      end
   end

   // S2: the larger operand is first, so the difference never goes negative.
   assign sum_d = sub1_q ? ({1'b0, big1_q} - {1'b0, sml1_q})
                         : ({1'b0, big1_q} + {1'b0, sml1_q});

   ahfp_norm #(.WIDTH(MW), .LZW(LZW)) u_norm (
      .data_i (sum2_q[MW-1:0]),
      .data_o (norm_s),
      .lzc_o  (lzc_s)
   );

   // S3: normalise, round to nearest even, then resolve zero/underflow/overflow.
   always_comb begin
      if (sum2_q[SW-1]) begin
         m_s = {sum2_q[SW-1:2], sum2_q[1] | sum2_q[0]};
         e_s = {2'b00, exp2_q} + XW'(1);
      end else begin
         m_s = norm_s;
         e_s = {2'b00, exp2_q} - XW'(lzc_s);
      end
      rnd_s = m_s[2] & (m_s[1] | m_s[0] | m_s[3]);
      mr_s  = {1'b0, m_s[MW-1:3]} + (MAN_W+2)'(rnd_s);
      if (mr_s[MAN_W+1]) begin
         man_s = mr_s[MAN_W:1];
         ef_s  = e_s + XW'(1);
      end else begin
         man_s = mr_s[MAN_W-1:0];
         ef_s  = e_s;
      end
      if (spec2_q) begin
         result_d = specres2_q;
      end else if (sum2_q == '0) begin
         result_d = ZERO;
      end else if (ef_s[XW-1] || ef_s == '0) begin
         result_d = ZERO;
      end else if (ef_s[XW-2:0] >= (XW-1)'(EXP_MAX)) begin
         result_d = {sign2_q, INF_POS[W-2:0]};
      end else begin
         result_d = {sign2_q, ef_s[EXP_W-1:0], man_s};
      end
   end

   // Valid bits and the output word are the only reset state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         v1_q        <= 1'b0;
         v2_q        <= 1'b0;
         out_valid_q <= 1'b0;
         result_q    <= '0;
      end else begin
         if (en1_s) v1_q <= in_valid & in_ready;
         if (en2_s) v2_q <= v1_q;
         if (en3_s) begin
            out_valid_q <= v2_q;
            result_q    <= result_d;
         end
      end
   end

   // Datapath stage registers, gated by the same enables as their valid bits.
   always_ff @(posedge clk) begin
      if (en1_s) begin
         spec1_q    <= spec_d;
         specres1_q <= specres_d;
         sign1_q    <= sign_d;
         sub1_q     <= sub_d;
         exp1_q     <= exp_d;
         big1_q     <= big_d;
         sml1_q     <= sml_d;
      end
      if (en2_s) begin
         spec2_q    <= spec1_q;
         specres2_q <= specres1_q;
         sign2_q    <= sign1_q;
         exp2_q     <= exp1_q;
         sum2_q     <= sum_d;
      end
   end

endmodule

// File: tb/tb_ahfp_addsub_pipe.sv
// Self-checking bench: directed vectors, stall/reset scenarios and a randomized
// stream scored against a real-arithmetic reference model.
module tb_ahfp_addsub_pipe;

   logic        clk;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic        op_sub;
   logic [31:0] dataa;
   logic [31:0] datab;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;

   int          checks;
   int          errors;
   int          cyc;
   int          stall_seen;
   int          stall_left;
   bit          rand_ready;
   bit          lat_chk;
   bit          accepted;
   bit          prev_stall;
   logic [31:0] prev_result;
   logic [31:0] pending_exp;
   logic [31:0] exp_q[$];
   int          cyc_q[$];

   ahfp_addsub_pipe #(.EXP_W(8), .MAN_W(23)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op_sub    (op_sub),
      .dataa     (dataa),
      .datab     (datab),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
      checks++;
      assert (got === expv) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, got, expv);
      end
   endtask

   function automatic real f2r(input logic [31:0] x);
      logic [63:0] d;
      if (x[30:23] == 8'd0) return 0.0;
      d = {x[31], {3'b000, x[30:23]} + 11'd896, x[22:0], 29'd0};
      return $bitstoreal(d);
   endfunction

   // Round an exactly representable double to single precision, nearest-even.
   function automatic logic [31:0] r2f(input real s);
      logic [63:0] d;
      logic [24:0] keep;
      logic [28:0] rest;
      int          e;
      d    = $realtobits(s);
      e    = int'(d[62:52]) - 896;
      keep = {2'b01, d[51:29]};
      rest = d[28:0];
      if (rest > 29'h1000_0000 || (rest == 29'h1000_0000 && keep[0])) keep = keep + 25'd1;
      if (keep[24]) begin
         keep = keep >> 1;
         e    = e + 1;
      end
      if (e >= 255) return {d[63], 8'hFF, 23'd0};
      if (e <= 0) return 32'd0;
      return {d[63], 8'(e), keep[22:0]};
   endfunction

   function automatic logic [31:0] ref_addsub(input logic [31:0] a, input logic [31:0] b,
                                              input logic sub);
      logic [31:0] bb;
      logic        a_nan, b_nan, a_inf, b_inf;
      real         s;
      bb    = {b[31] ^ sub, b[30:0]};
      a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
      b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
      a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
      b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
      if (a_nan || b_nan) return 32'h7FC0_0000;
      if (a_inf && b_inf) return (a[31] == bb[31]) ? {a[31], 8'hFF, 23'd0} : 32'h7FC0_0000;
      if (a_inf) return {a[31], 8'hFF, 23'd0};
      if (b_inf) return {bb[31], 8'hFF, 23'd0};
      s = f2r(a) + f2r(bb);
      if (s == 0.0) return 32'd0;
      return r2f(s);
   endfunction

   function automatic logic [31:0] rnd_op(input int e);
      return {1'($urandom_range(0, 1)), 8'(e), 23'($urandom)};
   endfunction

   // One clock: observe at the falling edge, then update out_ready after the rising edge.
   task automatic cycle();
      logic [31:0] e;
      int          c0;
      @(negedge clk);
      cyc++;
      accepted = 1'b0;
      if (out_valid && !out_ready) begin
         check("stall_in_ready", {31'd0, in_ready}, 32'd0);
         stall_seen++;
         if (prev_stall) check("stall_hold", result, prev_result);
      end
      prev_stall  = out_valid && !out_ready;
      prev_result = result;
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("spurious_out_valid", {31'd0, out_valid}, 32'd0);
         end else begin
            e  = exp_q.pop_front();
            c0 = cyc_q.pop_front();
            check("result", result, e);
            if (lat_chk) check("latency", 32'(cyc - c0), 32'd3);
         end
      end
      if (in_valid && in_ready) begin
         exp_q.push_back(pending_exp);
         cyc_q.push_back(cyc);
         accepted = 1'b1;
      end
      @(posedge clk);
      #1;
      if (stall_left > 0) stall_left--;
      out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : (stall_left == 0);
   endtask

   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic sub,
                       input logic [31:0] expv);
      int k;
      dataa       = a;
      datab       = b;
      op_sub      = sub;
      in_valid    = 1'b1;
      pending_exp = expv;
      accepted    = 1'b0;
      k           = 0;
      while (!accepted && k < 50) begin
         cycle();
         k++;
      end
      checks++;
      assert (accepted) else begin
         errors++;
         $error("FAIL accept_timeout: got in_ready=%0b expected transfer", in_ready);
      end
   endtask

   task automatic drain();
      int k;
      in_valid = 1'b0;
      k        = 0;
      while (exp_q.size() != 0 && k < 100) begin
         cycle();
         k++;
      end
      checks++;
      assert (exp_q.size() == 0) else begin
         errors++;
         $error("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      end
   endtask

   initial begin
      logic [31:0] a, b;
      logic        sub;
      int          ea, eb, kind;

      checks = 0; errors = 0; cyc = 0; stall_seen = 0; stall_left = 0;
      rand_ready = 1'b0; lat_chk = 1'b1; accepted = 1'b0; prev_stall = 1'b0;
      prev_result = 32'd0; pending_exp = 32'd0;
      reset_n = 1'b0; in_valid = 1'b0; op_sub = 1'b0; dataa = 32'd0; datab = 32'd0;
      out_ready = 1'b0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_result", result, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      reset_n   = 1'b1;
      out_ready = 1'b1;

      send(32'h3F80_0000, 32'h4000_0000, 1'b1, 32'hBF80_0000);
      drain();

      send(32'h3F80_0000, 32'h4000_0000, 1'b1, 32'hBF80_0000);
      send(32'h43FA_0000, 32'h4113_3333, 1'b1, 32'h43F5_6666);
      send(32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4040_0000);
      drain();

      lat_chk    = 1'b0;
      stall_seen = 0;
      send(32'h3F80_0000, 32'h4000_0000, 1'b1, 32'hBF80_0000);
      send(32'h43FA_0000, 32'h4113_3333, 1'b1, 32'h43F5_6666);
      send(32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4040_0000);
      stall_left = 4;
      out_ready  = 1'b0;
      send(32'h43FA_0000, 32'h4113_3333, 1'b1, 32'h43F5_6666);
      send(32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4040_0000);
      send(32'h3F80_0000, 32'h4000_0000, 1'b1, 32'hBF80_0000);
      drain();
      check("stall_cycles", 32'(stall_seen), 32'd4);

      lat_chk = 1'b1;
      send(32'h42FC_CCCD, 32'h42FC_CCCD, 1'b1, 32'h0000_0000);
      send(32'h7F80_0000, 32'h7F80_0000, 1'b1, 32'h7FC0_0000);
      send(32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000);
      send(32'hFF80_0000, 32'h3F80_0000, 1'b0, 32'hFF80_0000);
      send(32'h3F80_0000, 32'h7F80_0000, 1'b1, 32'hFF80_0000);
      send(32'h7FC1_2345, 32'h3F80_0000, 1'b0, 32'h7FC0_0000);
      send(32'h7F80_0000, 32'h7F80_0000, 1'b0, 32'h7F80_0000);
      send(32'h0001_2345, 32'h3F80_0000, 1'b0, 32'h3F80_0000);
      send(32'h8000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000);
      send(32'h0080_0000, 32'h00C0_0000, 1'b1, 32'h0000_0000);
      send(32'h3F80_0000, 32'h3380_0000, 1'b0, 32'h3F80_0000);
      send(32'h3F80_0001, 32'h3380_0000, 1'b0, 32'h3F80_0002);
      send(32'h3F80_0001, 32'h3280_0000, 1'b0, 32'h3F80_0001);
      drain();

      lat_chk    = 1'b0;
      rand_ready = 1'b1;
      for (int n = 0; n < 300; n++) begin
         ea = int'($urandom_range(1, 254));
         eb = ea + int'($urandom_range(0, 40)) - 20;
         if (eb < 1) eb = 1;
         if (eb > 254) eb = 254;
         a    = rnd_op(ea);
         b    = rnd_op(eb);
         sub  = 1'($urandom_range(0, 1));
         kind = int'($urandom_range(0, 15));
         case (kind)
            0: b = a;
            1: b = a ^ (32'd1 << $urandom_range(0, 22));
            2: a[30:23] = 8'd0;
            3: b = {b[31], 8'hFF, 23'd0};
            4: begin a[30:23] = 8'hFE; b[30:23] = 8'hFE; end
            default: ;
         endcase
         if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            cycle();
         end
         send(a, b, sub, ref_addsub(a, b, sub));
      end
      drain();

      rand_ready = 1'b0;
      out_ready  = 1'b1;
      send(32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4040_0000);
      send(32'h43FA_0000, 32'h4113_3333, 1'b1, 32'h43F5_6666);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      check("pre_reset_valid", {31'd0, out_valid}, 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      check("reset_out_valid", {31'd0, out_valid}, 32'd0);
      check("reset_in_ready", {31'd0, in_ready}, 32'd1);
      check("reset_result", result, 32'd0);
      exp_q.delete();
      cyc_q.delete();
      prev_stall = 1'b0;
      repeat (2) @(posedge clk);
      #3;
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      for (int n = 0; n < 8; n++) begin
         cycle();
         check("post_reset_quiet", {31'd0, out_valid}, 32'd0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
